// File: rtl/rwb_pkg.sv
// ============================================================================
// Module   : rwb_pkg
// Brief    : Shared constants and read-FSM state type for result_wb_buf.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rwb_pkg;
    localparam int RWB_DEPTH  = 4096;
    localparam int RWB_ADDR_W = 12;
    localparam int RWB_CNT_W  = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RSP  = 2'd2
    } rwb_state_t;
endpackage

`default_nettype wire

// File: rtl/rwb_ram.sv
// ============================================================================
// Module   : rwb_ram
// Brief    : 1W1R result RAM, synchronous read-first read port, no reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rwb_ram #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // A same-edge write to the read address is not visible here (read-first).
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;
endmodule

`default_nettype wire

// File: rtl/result_wb_buf.sv
// ============================================================================
// Module   : result_wb_buf
// Brief    : Captures the array result stream into RAM, tracks completion and
//            overflow, serves 32-bit reads. Option: RWB_BYPASS_EN (forwarding).
// Revision : 1.0
// ============================================================================
`default_nettype none

module result_wb_buf
    import rwb_pkg::*;
#(
    parameter int DEPTH  = RWB_DEPTH,
    parameter int ADDR_W = RWB_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [RWB_CNT_W-1:0] expected_cnt,
    input  logic [ADDR_W-1:0]    base_waddr,
    input  logic                 wen_n,
    input  logic [ADDR_W:0]      waddr,
    input  logic [63:0]          wdata,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [ADDR_W:0]      rd_req_addr,
    output logic                 rd_rsp_valid,
    input  logic                 rd_rsp_ready,
    output logic [31:0]          rd_rsp_data,
    output logic [RWB_CNT_W-1:0] wr_cnt,
    output logic                 wb_done,
    output logic                 ovf_err
);
    localparam logic [RWB_CNT_W-1:0] c_cnt_max = '1;

    logic [ADDR_W+1:0]    w_eff_addr;
    logic                 w_we;
    logic                 w_in_range;
    logic                 w_ram_we;
    logic                 w_accept;
    logic [63:0]          w_ram_rdata;
    logic [63:0]          w_rd_word;
    rwb_state_t           r_state;
    rwb_state_t           w_state_nxt;
    logic                 r_req_ready;
    logic                 r_half;
    logic [31:0]          r_rsp_data;
    logic [RWB_CNT_W-1:0] r_wr_cnt;
    logic                 r_wb_done;
    logic                 r_ovf_err;

    assign w_eff_addr = {2'b00, base_waddr} + {1'b0, waddr};
    assign w_we       = ~wen_n;
    assign w_in_range = (w_eff_addr < (ADDR_W + 2)'(DEPTH));
    assign w_ram_we   = w_we & w_in_range;

    rwb_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (64)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (w_eff_addr[ADDR_W-1:0]),
        .wdata (wdata),
        .re    (w_accept),
        .raddr (rd_req_addr[ADDR_W:1]),
        .rdata (w_ram_rdata)
    );

    // Dropped (out-of-range) strobes still count toward wr_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt  <= '0;
            r_wb_done <= 1'b0;
            r_ovf_err <= 1'b0;
        end else if (clear) begin
            r_wr_cnt  <= w_we ? RWB_CNT_W'(1) : '0;
            r_wb_done <= 1'b0;
            r_ovf_err <= w_we & ~w_in_range;
        end else begin
            if (w_we && (r_wr_cnt != c_cnt_max)) begin
                r_wr_cnt <= r_wr_cnt + RWB_CNT_W'(1);
            end
            if ((r_wr_cnt == expected_cnt) && (expected_cnt != '0)) begin
                r_wb_done <= 1'b1;
            end
            if (w_we && !w_in_range) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_req_valid && r_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RD;
                end
            end
            RD:      w_state_nxt = RSP;
            RSP: begin
                if (rd_rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef RWB_BYPASS_EN
    logic        r_byp_hit;
    logic [63:0] r_byp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp_hit <= 1'b0;
        end else if (w_accept) begin
            r_byp_hit <= w_ram_we && (w_eff_addr[ADDR_W-1:0] == rd_req_addr[ADDR_W:1]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_byp_data <= wdata;
        end
    end

    assign w_rd_word = r_byp_hit ? r_byp_data : w_ram_rdata;
`else
    assign w_rd_word = w_ram_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_half     <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_half <= rd_req_addr[0];
            end
            if (r_state == RD) begin
                r_rsp_data <= r_half ? w_rd_word[63:32] : w_rd_word[31:0];
            end
        end
    end

    assign rd_req_ready = r_req_ready;
    assign rd_rsp_valid = (r_state == RSP);
    assign rd_rsp_data  = r_rsp_data;
    assign wr_cnt       = r_wr_cnt;
    assign wb_done      = r_wb_done;
    assign ovf_err      = r_ovf_err;
endmodule

`default_nettype wire

// File: tb/tb_result_wb_buf.sv
// ============================================================================
// Module   : tb_result_wb_buf
// Brief    : Self-checking bench for result_wb_buf against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_result_wb_buf;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [12:0] expected_cnt;
    logic [11:0] base_waddr;
    logic        wen_n;
    logic [12:0] waddr;
    logic [63:0] wdata;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [12:0] rd_req_addr;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready;
    logic [31:0] rd_rsp_data;
    logic [12:0] wr_cnt;
    logic        wb_done;
    logic        ovf_err;

    result_wb_buf dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .expected_cnt (expected_cnt),
        .base_waddr   (base_waddr),
        .wen_n        (wen_n),
        .waddr        (waddr),
        .wdata        (wdata),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_data  (rd_rsp_data),
        .wr_cnt       (wr_cnt),
        .wb_done      (wb_done),
        .ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0] mem_m   [4096];
    bit          known_m [4096];
    int          words_q [$];
    int          cnt_m;
    bit          done_m;
    bit          ovf_m;
    int          phase_m;   // 0 waiting for request, 1 fetching, 2 responding
    bit          rdy_m;
    logic [31:0] rsp_m;
    logic [31:0] pend_m;
    bit          rand_on;

    task automatic check_val(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check_val("rd_req_ready", 64'(rd_req_ready), 64'(rdy_m));
        check_val("rd_rsp_valid", 64'(rd_rsp_valid), 64'(phase_m == 2));
        check_val("rd_rsp_data", 64'(rd_rsp_data), 64'(rsp_m));
        check_val("wr_cnt", 64'(wr_cnt), 64'(cnt_m));
        check_val("wb_done", 64'(wb_done), 64'(done_m));
        check_val("ovf_err", 64'(ovf_err), 64'(ovf_m));
    endtask

    // Advance one clock: model the edge from the current inputs, then compare.
    task automatic tick();
        logic [13:0] eff;
        bit          we;
        bit          inr;
        logic [63:0] word;
        int          nphase;
        if (rand_on) begin
            wen_n        = ($urandom_range(0, 2) == 0);
            waddr        = ($urandom_range(0, 15) == 0) ? 13'h1f80 + 13'($urandom_range(0, 63))
                                                        : 13'($urandom_range(0, 63));
            wdata        = {$urandom, $urandom};
            clear        = ($urandom_range(0, 59) == 0);
            rd_rsp_ready = 1'($urandom_range(0, 1));
            rd_req_valid = 1'b0;
            if (phase_m == 0 && rdy_m && words_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                rd_req_valid = 1'b1;
                rd_req_addr  = {12'(words_q[$urandom_range(0, words_q.size() - 1)]),
                                1'($urandom_range(0, 1))};
            end
        end
        eff = {2'b00, base_waddr} + {1'b0, waddr};
        we  = (wen_n == 1'b0);
        inr = (eff < 14'd4096);
        if (rst) begin
            cnt_m = 0; done_m = 0; ovf_m = 0; phase_m = 0; rdy_m = 0; rsp_m = '0;
        end else begin
            nphase = phase_m;
            if (phase_m == 0 && rdy_m && rd_req_valid) begin
                word = mem_m[rd_req_addr[12:1]];
`ifdef RWB_BYPASS_EN
                if (we && inr && eff[11:0] == rd_req_addr[12:1]) word = wdata;
`endif
                pend_m = rd_req_addr[0] ? word[63:32] : word[31:0];
                nphase = 1;
            end else if (phase_m == 1) begin
                rsp_m  = pend_m;
                nphase = 2;
            end else if (phase_m == 2 && rd_rsp_ready) begin
                nphase = 0;
            end
            phase_m = nphase;
            rdy_m   = (nphase == 0);
            if (clear) begin
                cnt_m  = we ? 1 : 0;
                done_m = 0;
                ovf_m  = we && !inr;
            end else begin
                if (cnt_m == int'(expected_cnt) && expected_cnt != 0) done_m = 1;
                if (we && cnt_m < 8191) cnt_m++;
                if (we && !inr) ovf_m = 1;
            end
        end
        if (we && inr) begin
            mem_m[eff[11:0]] = wdata;
            if (!known_m[eff[11:0]]) begin
                known_m[eff[11:0]] = 1;
                words_q.push_back(int'(eff[11:0]));
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(logic [12:0] a, logic [63:0] d);
        wen_n = 1'b0; waddr = a; wdata = d;
        tick();
        wen_n = 1'b1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_read(logic [12:0] a, int hold, logic [31:0] exp, string tag);
        rd_req_valid = 1'b1; rd_req_addr = a; rd_rsp_ready = 1'b0;
        tick();
        rd_req_valid = 1'b0;
        tick();
        tick();
        check_val(tag, 64'(rd_rsp_data), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            tick();
            check_val({tag, "_hold"}, 64'(rd_rsp_data), 64'(exp));
            check_val({tag, "_busy"}, 64'(rd_req_ready), 64'd0);
        end
        rd_rsp_ready = 1'b1;
        tick();
        rd_rsp_ready = 1'b0;
        check_val({tag, "_idle"}, 64'(rd_req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; expected_cnt = '0; base_waddr = '0;
        wen_n = 1'b1; waddr = '0; wdata = '0;
        rd_req_valid = 1'b0; rd_req_addr = '0; rd_rsp_ready = 1'b0;
        rand_on = 1'b0;
        cnt_m = 0; done_m = 0; ovf_m = 0; phase_m = 0; rdy_m = 0; rsp_m = '0; pend_m = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic write then both halves
        wr(13'd5, 64'h1122_3344_5566_7788);
        do_read(13'd10, 0, 32'h5566_7788, "basic_lo");
        do_read(13'd11, 0, 32'h1122_3344, "basic_hi");

        // Offset and overflow
        pulse_clear();
        base_waddr = 12'hFFE;
        wr(13'd1, 64'hCAFE_F00D_DEAD_BEEF);
        wr(13'd2, 64'h0123_4567_89AB_CDEF);
        check_val("ovf_set", 64'(ovf_err), 64'd1);
        check_val("ovf_cnt", 64'(wr_cnt), 64'd2);
        do_read({12'hFFF, 1'b0}, 0, 32'hDEAD_BEEF, "offset_rd");
        pulse_clear();
        check_val("ovf_clr", 64'(ovf_err), 64'd0);
        check_val("cnt_clr", 64'(wr_cnt), 64'd0);
        base_waddr = 12'h000;

        // Completion flag
        expected_cnt = 13'd3;
        pulse_clear();
        wr(13'd20, 64'h1);
        wr(13'd21, 64'h2);
        wr(13'd22, 64'h3);
        check_val("done_not_yet", 64'(wb_done), 64'd0);
        tick();
        check_val("done_set", 64'(wb_done), 64'd1);
        repeat (3) tick();
        check_val("done_sticky", 64'(wb_done), 64'd1);
        expected_cnt = 13'd0;
        pulse_clear();
        repeat (5) wr(13'd23, 64'h4);
        tick();
        check_val("done_zero_exp", 64'(wb_done), 64'd0);
        clear = 1'b1;
        wr(13'd24, 64'h5);
        clear = 1'b0;
        check_val("clear_strobe_cnt", 64'(wr_cnt), 64'd1);

        // Back-pressure on the response
        do_read(13'd10, 5, 32'h5566_7788, "bp");

        // Same-edge read and write of word 7
        wr(13'd7, 64'hA);
        wen_n = 1'b0; waddr = 13'd7; wdata = 64'hB;
        rd_req_valid = 1'b1; rd_req_addr = 13'd14; rd_rsp_ready = 1'b0;
        tick();
        wen_n = 1'b1; rd_req_valid = 1'b0;
        tick();
        tick();
`ifdef RWB_BYPASS_EN
        check_val("same_cycle", 64'(rd_rsp_data), 64'hB);
`else
        check_val("same_cycle", 64'(rd_rsp_data), 64'hA);
`endif
        rd_rsp_ready = 1'b1;
        tick();
        rd_rsp_ready = 1'b0;

        // Reset while a response is pending
        rd_req_valid = 1'b1; rd_req_addr = 13'd14;
        tick();
        rd_req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_val("rst_rsp_valid", 64'(rd_rsp_valid), 64'd0);
        check_val("rst_cnt", 64'(wr_cnt), 64'd0);
        rst = 1'b0;
        tick();
        do_read(13'd14, 0, 32'hB, "post_rst");

        // Randomized traffic
        base_waddr   = 12'h100;
        expected_cnt = 13'd20;
        pulse_clear();
        rand_on = 1'b1;
        repeat (600) tick();
        rand_on = 1'b0;
        wen_n = 1'b1; clear = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
